// File: rtl/xlib_xyz_pkg.sv
// Shared helpers for the xlib_xyz read-path blocks.
//   clog2  : ceiling log2 for parameter derivation
//   len_w  : width of a beat-length field (BL+1, holds 1..2**BL)
//   tag_w  : width of one tag-queue entry {channel id, length}
package xlib_xyz_pkg;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction

  function automatic int len_w(input int bl);
    return bl + 1;
  endfunction

  function automatic int tag_w(input int nc, input int bl);
    return clog2(nc) + bl + 1;
  endfunction

  // Widths for the default configuration (NC=2, BL=3)
  localparam int DEF_NC = 2;
  localparam int DEF_BL = 3;
  localparam int DEF_LW = DEF_BL + 1;
  localparam int DEF_TW = clog2(DEF_NC) + DEF_BL + 1;

endpackage

// File: rtl/xlib_xyz_tag_fifo.sv
// In-order tag queue: records {channel, length} of each issued burst.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write an entry (caller guarantees !full)
//   pop      : drop the head entry (caller guarantees !empty)
//   head     : current head entry
//   cnt      : number of stored entries (0..D)
//   full, empty
module xlib_xyz_tag_fifo
  import xlib_xyz_pkg::*;
#(
  parameter int W = DEF_TW,
  parameter int D = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W-1:0]          din,
  input  logic                  pop,
  output logic [W-1:0]          head,
  output logic [clog2(D):0]     cnt,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = clog2(D);

  logic [D-1:0][W-1:0] mem;
  logic [PW-1:0]       wp, rp;

  // D is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign head  = mem[rp];
  assign full  = (cnt == (PW+1)'(D));
  assign empty = (cnt == '0);

endmodule

// File: rtl/xlib_xyz_rd_arb.sv
// Round-robin read-bus arbiter for NC read-DMA channels sharing one burst
// read master.
//   clk, rst                          : clock, synchronous active-high reset
//   ch_rval/ch_rrdy/ch_rlen/ch_raddr  : per-channel burst requests (packed)
//   ch_rdval/ch_rdata                 : per-channel beat valid, shared data
//   bus_rval/bus_rrdy/bus_rlen/bus_raddr : registered command to the bus
//   bus_rdata/bus_rdval               : returned read beats
//   ost  : outstanding bursts, idle : nothing pending, err : sticky error
module xlib_xyz_rd_arb
  import xlib_xyz_pkg::*;
#(
  parameter int NC = 2,
  parameter int AW = 32,
  parameter int AL = 2,
  parameter int BL = 3,
  parameter int DW = 8 * (2 ** AL),
  parameter int OD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NC-1:0]          ch_rval,
  output logic [NC-1:0]          ch_rrdy,
  input  logic [NC*(BL+1)-1:0]   ch_rlen,
  input  logic [NC*AW-1:0]       ch_raddr,
  output logic [NC-1:0]          ch_rdval,
  output logic [DW-1:0]          ch_rdata,
  output logic                   bus_rval,
  input  logic                   bus_rrdy,
  output logic [BL:0]            bus_rlen,
  output logic [AW-1:0]          bus_raddr,
  input  logic [DW-1:0]          bus_rdata,
  input  logic                   bus_rdval,
  output logic [clog2(OD):0]     ost,
  output logic                   idle,
  output logic                   err
);

  localparam int CW = clog2(NC);
  localparam int LW = len_w(BL);
  localparam int TW = tag_w(NC, BL);

  logic [NC-1:0][LW-1:0] req_len;
  logic [NC-1:0][AW-1:0] req_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_ch
      assign req_len[gi]  = ch_rlen[gi*LW +: LW];
      assign req_addr[gi] = ch_raddr[gi*AW +: AW];
    end
  endgenerate

  // ---------------- round-robin selection ----------------
  logic [CW-1:0] rr, win, rr_nxt;
  logic [CW:0]   idx;
  logic          win_v;

  always_comb begin
    win   = '0;
    win_v = 1'b0;
    idx   = '0;
    for (int k = 0; k < NC; k++) begin
      idx = {1'b0, rr} + (CW+1)'(k);
      if (idx >= (CW+1)'(NC)) idx = idx - (CW+1)'(NC);
      if (!win_v && ch_rval[idx[CW-1:0]]) begin
        win_v = 1'b1;
        win   = idx[CW-1:0];
      end
    end
  end

  assign rr_nxt = (win == CW'(NC-1)) ? '0 : win + CW'(1);

  // ---------------- grant ----------------
  logic full, empty, slot_free, grant, fwd, zlen;

  assign slot_free = !bus_rval || bus_rrdy;
  // Full check uses the registered count: a same-cycle pop does not help.
  assign grant     = win_v && slot_free && !full;
  assign zlen      = grant && (req_len[win] == '0);
  assign fwd       = grant && !zlen;

  generate
    for (gi = 0; gi < NC; gi++) begin : g_rrdy
      assign ch_rrdy[gi] = grant && (win == CW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) rr <= '0;
    else if (grant) rr <= rr_nxt;
  end

  // ---------------- command slot ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rval  <= 1'b0;
      bus_rlen  <= '0;
      bus_raddr <= '0;
    end else if (fwd) begin
      bus_rval  <= 1'b1;
      bus_rlen  <= req_len[win];
      bus_raddr <= req_addr[win];
    end else if (bus_rrdy) begin
      bus_rval  <= 1'b0;
    end
  end

  // ---------------- tag queue + response routing ----------------
  logic [TW-1:0] head;
  logic [CW-1:0] hch;
  logic [LW-1:0] hlen, bcnt;
  logic          beat, last;

  assign hch  = head[TW-1 -: CW];
  assign hlen = head[LW-1:0];
  assign beat = bus_rdval && !empty;
  assign last = beat && (bcnt == hlen - LW'(1));

  xlib_xyz_tag_fifo #(.W(TW), .D(OD)) u_tag (
    .clk   (clk),
    .rst   (rst),
    .push  (fwd),
    .din   ({win, req_len[win]}),
    .pop   (last),
    .head  (head),
    .cnt   (ost),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) bcnt <= '0;
    else if (beat) bcnt <= last ? '0 : bcnt + LW'(1);
  end

  assign ch_rdata = bus_rdata;

  // Beats with an empty queue have no owner and are dropped.
  generate
    for (gi = 0; gi < NC; gi++) begin : g_rdval
      assign ch_rdval[gi] = beat && (hch == CW'(gi));
    end
  endgenerate

  // ---------------- status ----------------
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if ((bus_rdval && empty) || zlen) err <= 1'b1;
  end

  assign idle = (ost == '0) && !bus_rval;

endmodule

// File: tb/tb_xlib_xyz_rd_arb.sv
module tb_xlib_xyz_rd_arb;
  localparam int NC = 2, AW = 32, AL = 2, BL = 3, DW = 32, OD = 4;
  localparam int LW = BL + 1;
  localparam int NCYC = 2000;

  logic                 clk = 1'b0, rst = 1'b1;
  logic [NC-1:0]        ch_rval = '0, ch_rrdy, ch_rdval;
  logic [NC*LW-1:0]     ch_rlen = '0;
  logic [NC*AW-1:0]     ch_raddr = '0;
  logic [DW-1:0]        ch_rdata, bus_rdata = '0;
  logic                 bus_rval, bus_rrdy = 1'b0, bus_rdval = 1'b0;
  logic [BL:0]          bus_rlen;
  logic [AW-1:0]        bus_raddr;
  logic [2:0]           ost;
  logic                 idle, err;

  xlib_xyz_rd_arb #(.NC(NC), .AW(AW), .AL(AL), .BL(BL), .DW(DW), .OD(OD)) dut (
    .clk(clk), .rst(rst),
    .ch_rval(ch_rval), .ch_rrdy(ch_rrdy), .ch_rlen(ch_rlen), .ch_raddr(ch_raddr),
    .ch_rdval(ch_rdval), .ch_rdata(ch_rdata),
    .bus_rval(bus_rval), .bus_rrdy(bus_rrdy), .bus_rlen(bus_rlen), .bus_raddr(bus_raddr),
    .bus_rdata(bus_rdata), .bus_rdval(bus_rdval),
    .ost(ost), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: pending channel requests, slot, tag queue, bus beats
  bit          pv[NC];
  int          plen[NC];
  logic [31:0] paddr[NC];
  int          rr, beats;
  bit          slot_v, err_m, just_rst;
  int          slot_len;
  logic [31:0] slot_addr;
  int          tq_ch[$], tq_len[$], busq[$];

  initial begin
    int w;
    bit free, acc, newreq;
    logic [NC-1:0] exp_rrdy, exp_rdval;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk); #1;
      rst    = (cyc < 3) || (cyc == 1700);
      newreq = (cyc < 1500) || (cyc >= 1620);
      if (rst) begin
        ch_rval = '0; bus_rrdy = 1'b0; bus_rdval = 1'b0; bus_rdata = '0;
      end else begin
        for (int i = 0; i < NC; i++)
          if (!pv[i] && newreq && ($urandom % 3 == 0)) begin
            pv[i]    = 1;
            plen[i]  = int'($urandom_range(1, 1 << BL));
            paddr[i] = {$urandom, 2'b00} & 32'hffff_fffc;
          end
        if (cyc == 1610 && !pv[1]) begin   // zero-length request
          pv[1] = 1; plen[1] = 0; paddr[1] = 32'h40;
        end
        for (int i = 0; i < NC; i++) begin
          ch_rval[i]          = pv[i];
          ch_rlen[i*LW +: LW] = LW'(plen[i]);
          ch_raddr[i*AW +: AW] = paddr[i];
        end
        bus_rrdy  = newreq ? ($urandom % 10 < 7) : 1'b1;
        bus_rdval = (busq.size() > 0) && (!newreq || ($urandom % 10 < 6));
        if (cyc == 1605 && busq.size() == 0) bus_rdval = 1'b1;  // stray beat
        bus_rdata = $urandom;
      end

      @(negedge clk);
      if (!rst) begin
        free = !slot_v || bus_rrdy;
        w = -1;
        if (free && tq_ch.size() < OD)
          for (int k = 0; k < NC; k++)
            if (w < 0 && pv[(rr + k) % NC]) w = (rr + k) % NC;
        exp_rrdy  = (w >= 0) ? NC'(1 << w) : '0;
        exp_rdval = (bus_rdval && tq_ch.size() > 0) ? NC'(1 << tq_ch[0]) : '0;
        chk("ch_rrdy", ch_rrdy, exp_rrdy);
        chk("ch_rdval", ch_rdval, exp_rdval);
        chk("bus_rval", bus_rval, slot_v);
        if (slot_v) begin
          chk("bus_rlen", bus_rlen, slot_len);
          chk("bus_raddr", bus_raddr, slot_addr);
        end
        if (just_rst) begin
          chk("rst_rlen", bus_rlen, 0);
          chk("rst_raddr", bus_raddr, 0);
        end
        chk("ost", ost, tq_ch.size());
        chk("idle", idle, (tq_ch.size() == 0) && !slot_v);
        chk("err", err, err_m);
        if (bus_rdval) chk("ch_rdata", ch_rdata, bus_rdata);
        just_rst = 0;

        // advance the model across the coming edge; beats see pre-push state
        if (bus_rdval) begin
          if (tq_ch.size() == 0) err_m = 1;
          else begin
            beats++;
            if (beats == tq_len[0]) begin
              void'(tq_ch.pop_front()); void'(tq_len.pop_front()); beats = 0;
            end
          end
          if (busq.size() > 0) begin
            busq[0]--;
            if (busq[0] == 0) void'(busq.pop_front());
          end
        end
        acc = slot_v && bus_rrdy;
        if (acc) busq.push_back(slot_len);
        if (w >= 0) begin
          rr = (w + 1) % NC;
          pv[w] = 0;
          if (plen[w] != 0) begin
            tq_ch.push_back(w); tq_len.push_back(plen[w]);
            slot_v = 1; slot_len = plen[w]; slot_addr = paddr[w];
          end else begin
            err_m = 1;
            if (acc) slot_v = 0;
          end
        end else if (acc) slot_v = 0;
      end else begin
        for (int i = 0; i < NC; i++) pv[i] = 0;
        rr = 0; beats = 0; slot_v = 0; err_m = 0; just_rst = 1;
        tq_ch.delete(); tq_len.delete(); busq.delete();
      end
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/xlib_xyz_rd_arb.md
# xlib_xyz_rd_arb

Read-bus arbiter that lets NC read-DMA channels share one Avalon-style burst read master port. Round-robin arbitration grants burst commands, forwards them through a registered command stage, and records each issued burst's channel and length in an in-order tag queue. Returned read beats are steered back to the channel that issued the burst. It sits between the `xlib_xyz_dma_r` instances and the system bus interconnect.

## Interface
- NC, 2: number of read channels (2..8)
- AW, 32: byte address width
- AL, 2: log2 bytes per beat
- BL, 3: log2 maximum burst beats
- DW, 8*(2**AL): data width
- OD, 4: maximum outstanding bursts (power of two, 2..16)
- CW, clog2(NC): channel-id width (derived)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- ch_rval  in  NC  per-channel burst request valid
- ch_rrdy  out  NC  per-channel request accept; one-hot or zero
- ch_rlen  in  NC*(BL+1)  per-channel burst length in beats, 1..2**BL; channel i is at slice [i*(BL+1) +: BL+1]
- ch_raddr  in  NC*AW  per-channel burst address; channel i is at slice [i*AW +: AW]
- ch_rdval  out  NC  per-channel read beat valid
- ch_rdata  out  DW  read data, broadcast to all channels
- bus_rval  out  1  bus command valid
- bus_rrdy  in  1  bus command accept
- bus_rlen  out  BL+1  bus burst length
- bus_raddr  out  AW  bus address
- bus_rdata  in  DW  bus read data
- bus_rdval  in  1  bus read beat valid
- ost  out  clog2(OD)+1  number of outstanding bursts
- idle  out  1  high when ost==0 and bus_rval==0
- err  out  1  sticky protocol-error flag

## Operation
**Command slot**
- The slot holds bus_rval, bus_rlen and bus_raddr.
- The slot is free when bus_rval==0 or bus_rval&bus_rrdy.

**Grant**
- A grant happens when the slot is free, the tag queue is not full (ost<OD), and at least one ch_rval is high.
- The winner is chosen round-robin: the search starts at pointer rr and goes upward with wrap.
- On a grant:
  - ch_rrdy[w] is high in that cycle.
  - The winner's len and addr load into the slot, and bus_rval is set.
  - {w, len} is pushed into the tag queue.
  - rr becomes w+1 mod NC.
- If there is no grant but the slot is freed by the bus, bus_rval is cleared.

**Zero length**
- A request with ch_rlen==0 is still accepted (ch_rrdy pulses).
- It is not forwarded and not queued.
- err is set.
- rr advances as for a normal grant.

**Response routing**
- ch_rdata = bus_rdata, combinational.
- ch_rdval = bus_rdval steered to the channel id at the queue head, combinational.
- A beat counter increments on each bus_rdval.
- When the counter reaches (head len − 1), the head is popped and the counter clears.

**Error on empty queue**
- bus_rdval while the queue is empty sets err.
- The beat is dropped: all ch_rdval stay 0.

**ost accounting**
- ost increments on push and decrements on pop.
- A push and a pop in the same cycle leave ost unchanged.
- The full check uses the registered ost; a pop in the same cycle does not bypass it.

**Reset**
- All state clears and rr=0.
- Bursts in flight at reset are discarded. Their later beats set err, so the bus must be reset together with this block.

**err**
- err clears only on rst.

## Timing
- Reset values:
  - bus_rval=0, bus_rlen=0, bus_raddr=0
  - ch_rrdy=0, ch_rdval=0
  - ost=0, idle=1, err=0
  - ch_rdata follows bus_rdata
- Grant latency: ch_rrdy in cycle t gives bus_rval in cycle t+1.
- Back-to-back grants give 1 command per cycle while bus_rrdy is held high.
- Command hold: bus_rval, bus_rlen and bus_raddr stay stable until bus_rrdy is sampled high.
- Response latency is 0: a beat in cycle t appears on ch_rdval in cycle t.
- The pop takes effect at the next edge, so a beat in cycle t+1 already routes to the new head.
- Channels must hold ch_rval, ch_rlen and ch_raddr stable until ch_rrdy.
- ch_rrdy depends combinationally on ch_rval, on the registered slot state and on bus_rrdy.

## Structure
- Shared package `xlib_xyz_pkg`:
  - a clog2 function
  - the beat-length width BL+1
  - a tag-entry width localparam, TW = CW + BL + 1
- Sub-module `xlib_xyz_tag_fifo`:
  - synchronous, active-high reset
  - depth OD, width TW
  - ports: push, pop, head, cnt, full, empty
- Everything else stays in the top: round-robin selector, command slot, beat counter and error logic.

## Test plan
1. **Single request.** Ch0 requests addr 0x1000, len 4; bus_rrdy=1; bus returns 4 beats 0xA0..0xA3.
   - ch_rrdy[0] pulses for 1 cycle.
   - bus_raddr=0x1000 and bus_rlen=4 the next cycle.
   - ch_rdval[0] is high for exactly 4 beats with matching data.
   - ost goes 0→1→0; idle returns to 1.
2. **Round-robin.** NC=2; both channels hold requests continuously, len 2; bus_rrdy=1.
   - Grants alternate 0,1,0,1.
   - Responses are routed in grant order.
   - ch_rdval never goes to the wrong channel.
3. **Backpressure.** bus_rrdy=0 for 5 cycles with a command pending.
   - bus_rval, bus_rlen and bus_raddr stay stable.
   - No further ch_rrdy while the slot is occupied.
   - On bus_rrdy=1, the next grant is issued in that same cycle.
4. **Outstanding limit.** OD=4; issue 4 bursts with no responses.
   - ost=4 and ch_rrdy stays 0.
   - After the first burst's last beat, ost=3 and a grant occurs the following cycle.
5. **Error cases.**
   - bus_rdval with ost=0 → err=1 and no ch_rdval.
   - A ch_rlen=0 request → accepted, no bus command, err=1.
   - err remains set until rst.
6. **Reset mid-burst.** Assert rst after 2 of 4 beats.
   - All outputs return to their reset values the next cycle.
   - A subsequent fresh request behaves as in scenario 1.
